eight_three_encoder: RTL and testbench

EIGHT_THREE_ENCODER -- requirements
Module: eight_three_encoder

---
 rtl/enc_pkg.sv | 12 +
 rtl/pri_enc8.sv | 32 +++
 rtl/eight_three_encoder.sv | 112 +++++++++++
 tb/tb_eight_three_encoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared widths and FSM state type for the 8-to-3 draining encoder.
package enc_pkg;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned OUT_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } enc_state_t;

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-bit priority encoder with selectable search direction,
// plus any-set and exactly-one-set flags.
module pri_enc8
    import enc_pkg::*;
(
    input  logic [IN_W-1:0]  vec,
    input  logic             msb_first,
    output logic [OUT_W-1:0] idx,
    output logic             any,
    output logic             single
);

    logic [OUT_W-1:0] hi_idx;
    logic [OUT_W-1:0] lo_idx;

    // Ascending scan keeps the highest set bit; descending keeps the lowest.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (vec[i]) hi_idx = OUT_W'(i);
        end
        for (int i = int'(IN_W) - 1; i >= 0; i--) begin
            if (vec[i]) lo_idx = OUT_W'(i);
        end
    end

    assign idx    = msb_first ? hi_idx : lo_idx;
    assign any    = |vec;
    assign single = any && ((vec & (vec - IN_W'(1))) == '0);

endmodule

// File: rtl/eight_three_encoder.sv
// Accepts an 8-bit request vector and drains the index of every set bit, one
// per handshake. Define ENC_ZERO_REPORT_EN to emit a flagged beat for 8'h00.
module eight_three_encoder
    import enc_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  In,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] Out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_zero
);

    enc_state_t       state;
    enc_state_t       state_nxt;
    logic [IN_W-1:0]  pending;
    logic [IN_W-1:0]  pend_nxt;
    logic [IN_W-1:0]  clr_mask;
    logic             take;
    logic             load;
    logic             done;
    logic [OUT_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic             zero_beat;

`ifdef ENC_ZERO_REPORT_EN
    assign take      = 1'b1;
    assign zero_beat = !enc_any;
`else
    assign take      = |In;
    assign zero_beat = 1'b0;
`endif

    // pending holds every not-yet-acknowledged bit, including the one on Out.
    assign clr_mask = ~(IN_W'(1) << Out);

    // Encoder looks at the next pending value so Out is ready with no bubble.
    pri_enc8 u_pri_enc8 (
        .vec       (pend_nxt),
        .msb_first (MSB_FIRST),
        .idx       (enc_idx),
        .any       (enc_any),
        .single    (enc_single)
    );

    always_comb begin
        state_nxt = state;
        pend_nxt  = pending;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready && take) begin
                    pend_nxt  = In;
                    state_nxt = DRAIN;
                    load      = 1'b1;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        pend_nxt  = '0;
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end else begin
                        pend_nxt = pending & clr_mask;
                        load     = 1'b1;
                    end
                end
            end
            default: begin
                pend_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            in_ready  <= 1'b0;
            Out       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pend_nxt;
            in_ready <= (state_nxt == IDLE);
            if (load) begin
                Out       <= enc_idx;
                out_valid <= 1'b1;
                out_last  <= enc_single || !enc_any;
                out_zero  <= zero_beat;
            end else if (done) begin
                Out       <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eight_three_encoder.sv
// Directed bench: one MSB-first and one LSB-first instance share the stimulus.
module tb_eight_three_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       out_ready;

    logic       m_in_ready, m_out_valid, m_out_last, m_out_zero;
    logic [2:0] m_out;
    logic       l_in_ready, l_out_valid, l_out_last, l_out_zero;
    logic [2:0] l_out;

    int vectors;
    int errs;

    eight_three_encoder #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .In(in_vec), .in_valid(in_valid), .in_ready(m_in_ready),
        .Out(m_out), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_last(m_out_last), .out_zero(m_out_zero)
    );

    eight_three_encoder #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .In(in_vec), .in_valid(in_valid), .in_ready(l_in_ready),
        .Out(l_out), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_last(l_out_last), .out_zero(l_out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one beat on both instances: valid, index, last flag, zero flag.
    task automatic beat(input string tag, input int mo, input int ml, input int lo, input int ll);
        chk({tag, " m valid"}, int'(m_out_valid), 1);
        chk({tag, " m out"},   int'(m_out), mo);
        chk({tag, " m last"},  int'(m_out_last), ml);
        chk({tag, " m zero"},  int'(m_out_zero), 0);
        chk({tag, " l valid"}, int'(l_out_valid), 1);
        chk({tag, " l out"},   int'(l_out), lo);
        chk({tag, " l last"},  int'(l_out_last), ll);
        chk({tag, " l zero"},  int'(l_out_zero), 0);
        chk({tag, " m rdy"},   int'(m_in_ready), 0);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " m valid"}, int'(m_out_valid), 0);
        chk({tag, " l valid"}, int'(l_out_valid), 0);
        chk({tag, " m rdy"},   int'(m_in_ready), 1);
        chk({tag, " l rdy"},   int'(l_in_ready), 1);
    endtask

    initial begin
        vectors   = 0;
        errs      = 0;
        rst       = 1'b1;
        in_vec    = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        step();
        chk("rst m rdy",   int'(m_in_ready), 0);
        chk("rst m valid", int'(m_out_valid), 0);
        chk("rst m out",   int'(m_out), 0);
        chk("rst m last",  int'(m_out_last), 0);
        chk("rst l rdy",   int'(l_in_ready), 0);
        rst = 1'b0;
        chk("rel m rdy",   int'(m_in_ready), 0);
        step();
        idle_chk("post rst");

        // 1010_0100: MSB-first 7,5,2 ; LSB-first 2,5,7
        in_vec   = 8'b1010_0100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        beat("a0", 7, 0, 2, 0);
        step();
        beat("a1", 5, 0, 5, 0);
        step();
        beat("a2", 2, 1, 7, 1);
        step();
        idle_chk("a done");

        // Single bit with stalled consumer; In/in_valid ignored in DRAIN
        in_vec    = 8'h01;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_vec = 8'h80;
        beat("s0", 0, 1, 0, 1);
        step();
        beat("s1", 0, 1, 0, 1);
        step();
        beat("s2", 0, 1, 0, 1);
        step();
        beat("s3", 0, 1, 0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        idle_chk("s done");
        step();
        idle_chk("s stay");

        // All-zero vector
        in_vec   = 8'h00;
        in_valid = 1'b1;
        step();
`ifdef ENC_ZERO_REPORT_EN
        in_valid = 1'b0;
        chk("z m valid", int'(m_out_valid), 1);
        chk("z m zero",  int'(m_out_zero), 1);
        chk("z m last",  int'(m_out_last), 1);
        chk("z m out",   int'(m_out), 0);
        chk("z l zero",  int'(l_out_zero), 1);
        step();
        idle_chk("z done");
`else
        idle_chk("z0");
        step();
        idle_chk("z1");
        step();
        idle_chk("z2");
        chk("z m zero", int'(m_out_zero), 0);
        in_valid = 1'b0;
`endif

        // 8'hFF, reset after the second beat
        in_vec   = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        beat("f0", 7, 0, 0, 0);
        step();
        beat("f1", 6, 0, 1, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("f rst m valid", int'(m_out_valid), 0);
        chk("f rst l valid", int'(l_out_valid), 0);
        chk("f rst m out",   int'(m_out), 0);
        chk("f rst m last",  int'(m_out_last), 0);
        chk("f rst m rdy",   int'(m_in_ready), 0);
        step();
        rst = 1'b0;
        chk("f hold valid", int'(m_out_valid), 0);
        step();
        idle_chk("f rel");

        // Next vector after reset: 8'h10 -> single beat 4
        in_vec   = 8'h10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        beat("h0", 4, 1, 4, 1);
        step();
        idle_chk("h done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
